video_base_source: RTL and testbench

- Transmitting end of the effect-chain video stream. Generates raster timing (h_count, v_count, active_draw) and a base pixel.
- Feeds the multi-mux "from_base" inputs, which then route the stream to crush, distortion, filter and reverb stages or to the output.
- Base pixel is a background colour brightened by a per-frame drum-hit flash that decays frame by frame.

---
 rtl/video_pkg.sv | 27 ++
 rtl/video_timing_gen.sv | 48 ++++
 rtl/video_base_source.sv | 110 +++++++++++
 tb/tb_video_base_source.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video types, default 720p timing, saturating add and colour-bar table.
package video_pkg;
  typedef logic [23:0] pixel_t;
  typedef logic [10:0] h_count_t;
  typedef logic [9:0]  v_count_t;

  localparam int H_ACTIVE_720P = 1280;
  localparam int H_FP_720P     = 110;
  localparam int H_SYNC_720P   = 40;
  localparam int H_BP_720P     = 220;
  localparam int V_ACTIVE_720P = 720;
  localparam int V_FP_720P     = 5;
  localparam int V_SYNC_720P   = 5;
  localparam int V_BP_720P     = 20;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam pixel_t COLOR_BARS [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction
endpackage

// File: rtl/video_timing_gen.sv
// Raster h/v counters with sync/active decode and the frame-boundary strobe.
module video_timing_gen
  import video_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_720P,
  parameter int H_FP     = H_FP_720P,
  parameter int H_SYNC   = H_SYNC_720P,
  parameter int H_BP     = H_BP_720P,
  parameter int V_ACTIVE = V_ACTIVE_720P,
  parameter int V_FP     = V_FP_720P,
  parameter int V_SYNC   = V_SYNC_720P,
  parameter int V_BP     = V_BP_720P
) (
  input  logic     clk,
  input  logic     rst,
  output h_count_t h,
  output v_count_t v,
  output logic     fb,
  output logic     active,
  output logic     hs,
  output logic     vs
);
  localparam h_count_t H_LAST   = h_count_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam v_count_t V_LAST   = v_count_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam h_count_t H_ACT    = h_count_t'(H_ACTIVE);
  localparam v_count_t V_ACT    = v_count_t'(V_ACTIVE);
  localparam h_count_t HS_START = h_count_t'(H_ACTIVE + H_FP);
  localparam h_count_t HS_END   = h_count_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam v_count_t VS_START = v_count_t'(V_ACTIVE + V_FP);
  localparam v_count_t VS_END   = v_count_t'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + v_count_t'(1);
    end else begin
      h <= h + h_count_t'(1);
    end
  end

  assign fb     = (h == H_LAST) && (v == V_LAST);
  assign active = (h < H_ACT) && (v < V_ACT);
  assign hs     = (h >= HS_START) && (h < HS_END);
  assign vs     = (v >= VS_START) && (v < VS_END);
endmodule

// File: rtl/video_base_source.sv
// Base video source: raster timing plus background/flash pixel, one registered beat.
// Optional colour-bar test pattern enabled by VIDEO_BASE_SOURCE_PATTERN_EN.
module video_base_source
  import video_pkg::*;
#(
  parameter int H_ACTIVE   = H_ACTIVE_720P,
  parameter int H_FP       = H_FP_720P,
  parameter int H_SYNC     = H_SYNC_720P,
  parameter int H_BP       = H_BP_720P,
  parameter int V_ACTIVE   = V_ACTIVE_720P,
  parameter int V_FP       = V_FP_720P,
  parameter int V_SYNC     = V_SYNC_720P,
  parameter int V_BP       = V_BP_720P,
  parameter int DECAY_STEP = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] bg_color,
  input  logic        hit,
  input  logic        pattern_sel,
  output logic [10:0] h_count_to_mux,
  output logic [9:0]  v_count_to_mux,
  output logic        active_draw_to_mux,
  output logic [23:0] pixel_to_mux,
  output logic        h_sync,
  output logic        v_sync,
  output logic        new_frame,
  output logic [5:0]  frame_count
);
  localparam logic [7:0] DECAY8 = 8'(DECAY_STEP);

  h_count_t   h;
  v_count_t   v;
  logic       fb, active, hs, vs;
  logic [7:0] flash_level, decayed;
  logic       hit_pending;
  pixel_t     bg_lat, pix_flash, pix_next;
  logic [5:0] fc;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst(rst), .h(h), .v(v), .fb(fb),
    .active(active), .hs(hs), .vs(vs)
  );

  assign decayed = (flash_level > DECAY8) ? flash_level - DECAY8 : 8'h00;

  // Frame-latched state only moves at FB, so a frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flash_level <= '0;
      hit_pending <= 1'b0;
      bg_lat      <= '0;
      fc          <= '0;
    end else if (fb) begin
      flash_level <= (hit_pending || hit) ? 8'hFF : decayed;
      hit_pending <= 1'b0;
      bg_lat      <= bg_color;
      fc          <= fc + 6'd1;
    end else if (hit) begin
      hit_pending <= 1'b1;
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_ch
    assign pix_flash[c*8 +: 8] = sat_add8(bg_lat[c*8 +: 8], flash_level);
  end

`ifdef VIDEO_BASE_SOURCE_PATTERN_EN
  localparam h_count_t BAR_W = h_count_t'(H_ACTIVE / 8);
  logic       pat_lat;
  logic [2:0] bar_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     pat_lat <= 1'b0;
    else if (fb) pat_lat <= pattern_sel;
  end

  assign bar_idx  = 3'(h / BAR_W);
  assign pix_next = pat_lat ? COLOR_BARS[bar_idx] : pix_flash;
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pix_next           = pix_flash;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_count_to_mux     <= '0;
      v_count_to_mux     <= '0;
      active_draw_to_mux <= 1'b0;
      pixel_to_mux       <= '0;
      h_sync             <= 1'b0;
      v_sync             <= 1'b0;
      new_frame          <= 1'b0;
      frame_count        <= '0;
    end else begin
      h_count_to_mux     <= h;
      v_count_to_mux     <= v;
      active_draw_to_mux <= active;
      pixel_to_mux       <= active ? pix_next : '0;
      h_sync             <= hs;
      v_sync             <= vs;
      new_frame          <= (h == '0) && (v == '0);
      frame_count        <= fc;
    end
  end
endmodule

// File: tb/tb_video_base_source.sv
// Randomised-input bench for video_base_source on a reduced raster, checked against a frame-level model.
module tb_video_base_source;
  localparam int HA = 16, HF = 2, HS = 3, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1, VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int DS = 8;

  logic clk = 1'b0, rst = 1'b1;
  logic [23:0] bg_color = 24'h0;
  logic hit = 1'b0, pattern_sel = 1'b0;
  logic [10:0] h_count_to_mux;
  logic [9:0]  v_count_to_mux;
  logic        active_draw_to_mux, h_sync, v_sync, new_frame;
  logic [23:0] pixel_to_mux;
  logic [5:0]  frame_count;

  video_base_source #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .DECAY_STEP(DS)
  ) dut (
    .clk(clk), .rst(rst), .bg_color(bg_color), .hit(hit), .pattern_sel(pattern_sel),
    .h_count_to_mux(h_count_to_mux), .v_count_to_mux(v_count_to_mux),
    .active_draw_to_mux(active_draw_to_mux), .pixel_to_mux(pixel_to_mux),
    .h_sync(h_sync), .v_sync(v_sync), .new_frame(new_frame), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int n = 0;
  bit mon_en = 0;
  int m_flash = 0, m_pend = 0, m_fc = 0;
  logic [23:0] m_bg = 24'h0;
  bit m_pat = 0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  logic [23:0] log_pix [0:127];
  logic [5:0]  log_fc  [0:127];
  logic [23:0] row66   [0:HA-1];
  int act_cnt = 0, hs_cnt = 0, vs_cnt = 0, nf_last = -1, nf_gap = 0;
  logic first_nf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ch(input logic [7:0] b, input int f);
    int s;
    s = int'(b) + f;
    return (s > 255) ? 8'hFF : s[7:0];
  endfunction

  // Model: beat index n maps directly to raster position; per-frame state changes at the last beat.
  always @(posedge clk) begin
    int p, h, v, f, e_fc;
    logic [23:0] e_pix;
    bit e_act, e_hs, e_vs, e_nf;
    if (mon_en && !rst) begin
      p = n % FR; h = p % HT; v = p / HT; f = n / FR;
      e_act = (h < HA) && (v < VA);
      e_hs  = (h >= HA + HF) && (h < HA + HF + HS);
      e_vs  = (v >= VA + VF) && (v < VA + VF + VS);
      e_nf  = (p == 0);
      e_fc  = m_fc % 64;
      if (!e_act)     e_pix = 24'h0;
      else if (m_pat) e_pix = bars[h / (HA / 8)];
      else            e_pix = {ch(m_bg[23:16], m_flash), ch(m_bg[15:8], m_flash), ch(m_bg[7:0], m_flash)};
      if (p == FR - 1) begin
        m_flash = (m_pend != 0 || hit) ? 255 : ((m_flash > DS) ? m_flash - DS : 0);
        m_bg    = bg_color;
`ifdef VIDEO_BASE_SOURCE_PATTERN_EN
        m_pat   = pattern_sel;
`endif
        m_fc++;
        m_pend  = 0;
      end else if (hit) m_pend = 1;
      n++;
      #1;
      if (!rst) begin
        chk("h_count", 32'(h_count_to_mux), 32'(h));
        chk("v_count", 32'(v_count_to_mux), 32'(v));
        chk("active",  32'(active_draw_to_mux), 32'(e_act));
        chk("pixel",   32'(pixel_to_mux), 32'(e_pix));
        chk("h_sync",  32'(h_sync), 32'(e_hs));
        chk("v_sync",  32'(v_sync), 32'(e_vs));
        chk("new_frame", 32'(new_frame), 32'(e_nf));
        chk("frame_count", 32'(frame_count), 32'(e_fc));
        if (n == 1) first_nf = new_frame;
        if (f < 128 && p == 0) begin log_pix[f] = pixel_to_mux; log_fc[f] = frame_count; end
        if (f == 66 && v == 0 && h < HA) row66[h] = pixel_to_mux;
        if (f == 1) begin
          act_cnt += int'(active_draw_to_mux);
          vs_cnt  += int'(v_sync);
          if (v == 0) hs_cnt += int'(h_sync);
        end
        if (new_frame) begin
          if (nf_last >= 0) nf_gap = n - nf_last;
          nf_last = n;
        end
      end
    end
  end

  task automatic wait_n(input int e);
    while (n < e) @(negedge clk);
  endtask

  task automatic pulse_hit(input int e, input int len);
    wait_n(e);
    hit = 1'b1;
    repeat (len) @(negedge clk);
    hit = 1'b0;
  endtask

  // Random bg writes mid-frame before the latch point must not affect the current frame.
  task automatic jitter_bg(input int e, input logic [23:0] final_bg);
    wait_n(e);
    repeat ($urandom_range(1, 5)) @(negedge clk) bg_color = 24'($urandom);
    bg_color = final_bg;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bg_color = 24'h102030;
    #23;
    chk("reset_h", 32'(h_count_to_mux), 32'h0);
    chk("reset_pix", 32'(pixel_to_mux), 32'h0);
    chk("reset_nf", 32'(new_frame), 32'h0);
    chk("reset_fc", 32'(frame_count), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1;

    jitter_bg(FR / 3, 24'h102030);
    pulse_hit(2 * FR + 100, 1);
    jitter_bg(4 * FR + 40, 24'h000000);
    pulse_hit(37 * FR - 1, 1);            // exactly on the FB beat of frame 36
    pulse_hit(38 * FR + 30, 10);          // long hit counts once
    wait_n(65 * FR + 20);
    pattern_sel = 1'b1;
    wait_n(67 * FR + 10);

    chk("stat_active", 32'(act_cnt), 32'd128);
    chk("stat_hsync",  32'(hs_cnt),  32'd3);
    chk("stat_vsync",  32'(vs_cnt),  32'd48);
    chk("stat_nf_gap", 32'(nf_gap),  32'd288);
    chk("first_nf",    32'(first_nf), 32'h1);
    chk("f0_pix",  32'(log_pix[0]),  32'h000000);
    chk("f1_pix",  32'(log_pix[1]),  32'h102030);
    chk("f2_pix",  32'(log_pix[2]),  32'h102030);
    chk("f3_pix",  32'(log_pix[3]),  32'hFFFFFF);
    chk("f4_pix",  32'(log_pix[4]),  32'hFFFFFF);
    chk("f5_pix",  32'(log_pix[5]),  32'hEFEFEF);
    chk("f34_pix", 32'(log_pix[34]), 32'h070707);
    chk("f35_pix", 32'(log_pix[35]), 32'h000000);
    chk("f37_pix", 32'(log_pix[37]), 32'hFFFFFF);
    chk("f40_pix", 32'(log_pix[40]), 32'hF7F7F7);
    chk("f1_fc",   32'(log_fc[1]),   32'd1);
    chk("f63_fc",  32'(log_fc[63]),  32'd63);
    chk("f64_fc",  32'(log_fc[64]),  32'd0);
`ifdef VIDEO_BASE_SOURCE_PATTERN_EN
    chk("bar_h0",  32'(row66[0]),      32'hFFFFFF);
    chk("bar_h2",  32'(row66[HA / 8]), 32'hFFFF00);
    chk("bar_end", 32'(row66[HA - 1]), 32'h000000);
`else
    chk("nobar_h0",  32'(row66[0]),      32'h272727);
    chk("nobar_h2",  32'(row66[HA / 8]), 32'h272727);
    chk("nobar_end", 32'(row66[HA - 1]), 32'h272727);
`endif

    // Asynchronous reset mid-line.
    #2;
    rst = 1'b1;
    mon_en = 0;
    #1;
    chk("areset_h",   32'(h_count_to_mux), 32'h0);
    chk("areset_v",   32'(v_count_to_mux), 32'h0);
    chk("areset_act", 32'(active_draw_to_mux), 32'h0);
    chk("areset_pix", 32'(pixel_to_mux), 32'h0);
    chk("areset_sync", 32'({h_sync, v_sync, new_frame}), 32'h0);
    chk("areset_fc",  32'(frame_count), 32'h0);
    pattern_sel = 1'b0;
    bg_color = 24'h405060;
    repeat (3) @(negedge clk);
    n = 0; m_flash = 0; m_pend = 0; m_fc = 0; m_bg = 24'h0; m_pat = 0; first_nf = 1'b0;
    rst = 1'b0;
    mon_en = 1;
    wait_n(2 * FR + 5);
    chk("rst2_first_nf", 32'(first_nf),   32'h1);
    chk("rst2_f0_pix",   32'(log_pix[0]), 32'h000000);
    chk("rst2_f1_pix",   32'(log_pix[1]), 32'h405060);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
